// File: rtl/flit_stream_monitor.sv
// Flit stream monitor: delimits packets, reports length/toggle summaries through one valid/ready slot.
// Summary appears one cycle after the close cycle. The input is never stalled; a summary that finds the slot full is dropped.
module flit_stream_monitor #(
  parameter int N       = 25,
  parameter int PAYLOAD = 20,
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 16,
  parameter int TOT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     in_op1,
  input  logic [N-1:0]     in_op2,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  output logic [CNT_W-1:0] pkt_len,
  output logic [CNT_W-1:0] pkt_toggles,
  output logic             pkt_len_err,
  output logic [TOT_W-1:0] total_toggles,
  output logic [7:0]       drop_cnt,
  output logic             busy
);

  localparam int FW  = 2 * N;
  localparam int D_W = $clog2(FW + 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state, state_n;
  logic [FW-1:0]    flit, prev_flit, diff;
  logic [D_W-1:0]   d;
  logic [CNT_W-1:0] len_acc, len_n, tog_acc, tog_n, tog_sum;
  logic [CNT_W-1:0] close_len, close_tog;
  logic [CNT_W:0]   tog_wide;
  logic [TOT_W:0]   tot_wide;
  logic             close, load, pop;

  assign flit = {in_op2, in_op1};
  assign diff = flit ^ prev_flit;

  always_comb begin
    d = '0;
    for (int i = 0; i < FW; i++) begin
      d = d + D_W'(diff[i]);
    end
  end

  // A packet's first flit starts its toggle sum from zero rather than from the stale accumulator.
  assign tog_wide = {1'b0, (state == RECV) ? tog_acc : {CNT_W{1'b0}}} + (CNT_W+1)'(d);
  assign tog_sum  = tog_wide[CNT_W] ? {CNT_W{1'b1}} : tog_wide[CNT_W-1:0];
  assign tot_wide = {1'b0, total_toggles} + (TOT_W+1)'(d);

  always_comb begin
    state_n   = state;
    len_n     = len_acc;
    tog_n     = tog_acc;
    close     = 1'b0;
    close_len = len_acc;
    close_tog = tog_acc;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = RECV;
          len_n   = CNT_W'(1);
          tog_n   = tog_sum;
        end
      end
      RECV: begin
        if (in_valid && (len_acc < CNT_W'(MAX_LEN - 1))) begin
          len_n = len_acc + CNT_W'(1);
          tog_n = tog_sum;
        end else begin
          close   = 1'b1;
          state_n = IDLE;
          len_n   = '0;
          tog_n   = '0;
          if (in_valid) begin
            close_len = CNT_W'(MAX_LEN);
            close_tog = tog_sum;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop  = pkt_valid && pkt_ready;
  assign load = close && (!pkt_valid || pkt_ready);
  assign busy = (state == RECV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      prev_flit     <= '0;
      len_acc       <= '0;
      tog_acc       <= '0;
      total_toggles <= '0;
    end else begin
      state   <= state_n;
      len_acc <= len_n;
      tog_acc <= tog_n;
      if (in_valid) begin
        prev_flit     <= flit;
        total_toggles <= tot_wide[TOT_W] ? {TOT_W{1'b1}} : tot_wide[TOT_W-1:0];
      end
    end
  end

  // Report slot: load and pop in the same cycle keeps pkt_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_valid   <= 1'b0;
      pkt_len     <= '0;
      pkt_toggles <= '0;
      pkt_len_err <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      if (load) begin
        pkt_valid   <= 1'b1;
        pkt_len     <= close_len;
        pkt_toggles <= close_tog;
        pkt_len_err <= (close_len != CNT_W'(PAYLOAD));
      end else if (pop) begin
        pkt_valid <= 1'b0;
      end
      if (close && !load && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_flit_stream_monitor.sv
// Directed bench for flit_stream_monitor: packet vector table plus hand-written corner sequences.
module tb_flit_stream_monitor;
  localparam int N  = 25;
  localparam int FW = 2 * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [N-1:0]  in_op1, in_op2;
  logic          pkt_valid, pkt_ready, pkt_len_err, busy;
  logic [15:0]   pkt_len, pkt_toggles;
  logic [31:0]   total_toggles;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flit_stream_monitor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op1(in_op1), .in_op2(in_op2),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_len(pkt_len),
    .pkt_toggles(pkt_toggles), .pkt_len_err(pkt_len_err),
    .total_toggles(total_toggles), .drop_cnt(drop_cnt), .busy(busy)
  );

  typedef struct {
    bit          rst_before;
    int          n;
    logic [FW-1:0] f0;
    logic [FW-1:0] f1;
    int          gap;
    int          e_len;
    int          e_tog;
    bit          e_err;
    int          e_tot;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [FW-1:0] f);
    in_valid = 1'b1;
    {in_op2, in_op1} = f;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    {in_op2, in_op1} = '0;
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, 64'(pkt_valid), 64'd0);
    chk({tag, " len"}, 64'(pkt_len), 64'd0);
    chk({tag, " tog"}, 64'(pkt_toggles), 64'd0);
    chk({tag, " err"}, 64'(pkt_len_err), 64'd0);
    chk({tag, " total"}, 64'(total_toggles), 64'd0);
    chk({tag, " drop"}, 64'(drop_cnt), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_sum(input string tag, input int len, input int tog, input bit err, input int tot);
    chk({tag, " valid"}, 64'(pkt_valid), 64'd1);
    chk({tag, " len"}, 64'(pkt_len), 64'(len));
    chk({tag, " tog"}, 64'(pkt_toggles), 64'(tog));
    chk({tag, " err"}, 64'(pkt_len_err), 64'(err));
    chk({tag, " total"}, 64'(total_toggles), 64'(tot));
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    {in_op2, in_op1} = '0;
    rst = 1'b1;
    #2;
    chk_zero(tag);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [FW-1:0] ones, pa, pb;
    string tag;
    ones = '1;
    pa = 50'h3FFFFF8000000;
    pb = 50'h3FFFFFFFFFFF0;
    tv[0] = '{1'b0, 20, ones, 50'd0, 7, 20, 1000, 1'b0, 1000};
    tv[1] = '{1'b0, 2, pa, pb, 7, 2, 46, 1'b1, 1046};
    tv[2] = '{1'b1, 20, 50'd1, 50'd1, 7, 20, 1, 1'b0, 1};
    for (int k = 3; k < 12; k++) tv[k] = '{1'b0, 20, 50'd1, 50'd1, 7, 20, 0, 1'b0, 1};

    pkt_ready = 1'b1;
    do_reset("reset");

    for (int k = 0; k < 12; k++) begin
      if (tv[k].rst_before) do_reset($sformatf("v%0d reset", k));
      for (int i = 0; i < tv[k].n; i++) send((i % 2 == 0) ? tv[k].f0 : tv[k].f1);
      chk($sformatf("v%0d busy", k), 64'(busy), 64'd1);
      idle();
      chk_sum($sformatf("v%0d", k), tv[k].e_len, tv[k].e_tog, tv[k].e_err, tv[k].e_tot);
      chk($sformatf("v%0d busy_off", k), 64'(busy), 64'd0);
      chk($sformatf("v%0d drop", k), 64'(drop_cnt), 64'd0);
      idle();
      chk($sformatf("v%0d valid_off", k), 64'(pkt_valid), 64'd0);
      for (int g = 2; g < tv[k].gap; g++) idle();
    end

    // Slot full: second summary dropped, third replaces first without a gap in pkt_valid.
    pkt_ready = 1'b0;
    for (int i = 0; i < 20; i++) send((i % 2 == 0) ? 50'h1 : 50'h3);
    idle();
    chk_sum("hold1", 20, 19, 1'b0, 20);
    for (int g = 0; g < 6; g++) idle();
    chk("hold1 valid_kept", 64'(pkt_valid), 64'd1);
    for (int i = 0; i < 5; i++) send(50'hF);
    idle();
    chk_sum("hold2", 20, 19, 1'b0, 22);
    chk("hold2 drop", 64'(drop_cnt), 64'd1);
    for (int g = 0; g < 6; g++) idle();
    for (int i = 0; i < 3; i++) begin
      send(50'h0);
      chk($sformatf("hold3 valid_kept%0d", i), 64'(pkt_valid), 64'd1);
    end
    pkt_ready = 1'b1;
    idle();
    chk_sum("reload", 3, 4, 1'b1, 26);
    chk("reload drop", 64'(drop_cnt), 64'd1);
    idle();
    chk("reload valid_off", 64'(pkt_valid), 64'd0);

    // 70 flits back to back: forced close at 64, then a 6-flit packet.
    for (int i = 0; i < 70; i++) begin
      send(FW'(i % 2));
      if (i == 62) chk("max busy62", 64'(busy), 64'd1);
      if (i == 63) begin
        chk_sum("max first", 64, 63, 1'b1, 89);
        chk("max busy_gap", 64'(busy), 64'd0);
      end
      if (i == 64) begin
        chk("max busy_restart", 64'(busy), 64'd1);
        chk("max valid_popped", 64'(pkt_valid), 64'd0);
      end
    end
    idle();
    chk_sum("max second", 6, 6, 1'b1, 95);
    idle();

    // Reset in the middle of a packet.
    for (int i = 0; i < 10; i++) send(ones);
    chk("mid busy", 64'(busy), 64'd1);
    chk("mid total", 64'(total_toggles), 64'd144);
    rst = 1'b1;
    #2;
    chk_zero("midrst");
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    idle();
    chk("midrst no_summary", 64'(pkt_valid), 64'd0);
    for (int i = 0; i < 20; i++) send(ones);
    idle();
    chk_sum("after_rst", 20, 50, 1'b0, 50);
    chk("after_rst drop", 64'(drop_cnt), 64'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flit_stream_monitor.md
Name: flit_stream_monitor

Overview:
- Receive-end monitor for the flit-injection link that drives operand pairs into the adder during energy characterization.
- Observes the link as a two-operand flit stream and delimits packets.
- For each packet it measures length and switching activity, as the sum of bit toggles between consecutive flits.
- Returns one summary per packet to the characterization harness over a valid/ready handshake, plus a running total for energy estimation.

Parameters:
- N, 25, operand width; flit width is 2*N, with flit = {in_op2, in_op1}.
- PAYLOAD, 20, expected flits per packet; any other length sets the length-error flag.
- MAX_LEN, 64, maximum flits per packet before a forced close.
- CNT_W, 16, width of per-packet toggle counter and of length fields.
- TOT_W, 32, width of the running total-toggle counter.

Ports:
- clk  in  1  link clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  a flit is present this cycle.
- in_op1  in  N  low half of flit (operand 1).
- in_op2  in  N  high half of flit (operand 2).
- pkt_valid  out  1  a packet summary is held.
- pkt_ready  in  1  harness accepts the summary.
- pkt_len  out  CNT_W  flits in the reported packet.
- pkt_toggles  out  CNT_W  sum of Hamming distances for the packet's flits.
- pkt_len_err  out  1  pkt_len != PAYLOAD.
- total_toggles  out  TOT_W  saturating sum of all flit toggles since reset.
- drop_cnt  out  8  summaries lost because the slot was full; saturates at 255.
- busy  out  1  a packet is in progress (state RECV).

Behaviour:
- Reset (async, immediate) clears everything:
  - state=IDLE; prev_flit=0; len_acc=0; tog_acc=0.
  - All outputs 0: pkt_valid, pkt_len, pkt_toggles, pkt_len_err, total_toggles, drop_cnt, busy.
  - Reset mid-packet discards the packet with no report.
- Toggle arithmetic, for each cycle with in_valid=1:
  - d = popcount(flit XOR prev_flit), range 0..2N.
  - prev_flit <= flit. prev_flit changes only on valid cycles; idle cycles do not count toggles.
  - prev_flit persists across packet boundaries, so the first flit of a packet is compared with the last flit of the previous packet (0 after reset).
- total_toggles += d each valid cycle, saturating at 2^TOT_W-1.
- tog_acc saturates at 2^CNT_W-1; len_acc never exceeds MAX_LEN.
- FSM state IDLE:
  - in_valid=1 -> RECV, with len_acc=1 and tog_acc=d.
- FSM state RECV:
  - in_valid=1 and len_acc<MAX_LEN-1 -> len_acc+1, tog_acc+d; stay in RECV.
  - in_valid=1 and len_acc==MAX_LEN-1 -> forced close including this flit (len=MAX_LEN), go to IDLE. A flit on the next cycle starts a new packet.
  - in_valid=0 -> close with the current len_acc/tog_acc, go to IDLE.
- Close event:
  - The summary {len, toggles, len!=PAYLOAD} is offered to the single report slot.
  - The slot loads if it is empty, or if pkt_valid&&pkt_ready in the same cycle (pop and load together; pkt_valid stays 1).
  - Otherwise the summary is dropped and drop_cnt increments (saturating).
- Latency: pkt_valid rises on the clock edge that samples the close cycle, i.e. it is visible one cycle after the first idle cycle (or after the MAX_LEN-th flit).
- Handshake:
  - pkt_valid is held with stable fields until the cycle pkt_valid&&pkt_ready; it then deasserts on the next edge unless reloaded.
  - pkt_ready is ignored while pkt_valid=0.
- busy=1 exactly while state=RECV.
- Idle gap length is unconstrained. Back-to-back packets require at least one in_valid=0 cycle, except after a MAX_LEN close.
- The input has no backpressure: flits are never stalled or lost; only summaries can drop.

Test Plan:
- Reset, then 20 flits alternating all-ones / all-zeros (first all-ones), then 7 idle cycles, pkt_ready=1 -> pkt_len=20, pkt_toggles=1000, pkt_len_err=0, total_toggles=1000. pkt_valid is high one cycle after the first idle cycle, for one cycle.
- Flits 0x3FFFFF8000000 then 0x3FFFFFFFFFFF0 (in_op2/in_op1 halves), then idle -> pkt_len=2, pkt_toggles=46, pkt_len_err=1.
- Ten packets of 20 constant flits 0x1 with 7-cycle gaps -> the first packet reports toggles=1 and the rest report 0. total_toggles=1; ten summaries are accepted and drop_cnt=0.
- pkt_ready held 0 across two packets of length 20 and 5 -> the first summary is held unchanged and drop_cnt=1. Raise pkt_ready in the close cycle of a third packet -> the third summary replaces the first with pkt_valid continuously high.
- 70 consecutive valid flits -> first summary len=64, err=1. busy drops for one cycle, then a second packet of 6 flits is reported with len=6.
- Assert rst mid-packet after 10 flits -> all outputs 0 asynchronously, no summary. The next 20-flit packet reports toggles computed against prev_flit=0.
